norm_sequencer: RTL



---
 rtl/fp_add_pkg.sv | 22 ++
 rtl/norm_sequencer_lzc_counter.sv | 21 ++
 rtl/norm_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_add_pkg.sv
// Shared FP adder types and constants: default widths, exponent ceiling,
// normalizer FSM states and exponent adjuster mode encodings.
package fp_add_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 24;
   localparam int LZC_W_DEF = 5;

   localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;

   localparam logic ADJ_INC = 1'b0;
   localparam logic ADJ_DEC = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      ANALYZE,
      ISSUE,
      CAPTURE,
      DONE
   } norm_state_t;

endpackage

// File: rtl/norm_sequencer_lzc_counter.sv
// Combinational leading-zero counter for the raw mantissa sum.
// An all-zero input reports MAN_W.
module lzc_counter
   import fp_add_pkg::*;
#(
   parameter int MAN_W = MAN_W_DEF,
   parameter int LZC_W = LZC_W_DEF
) (
   input  logic [MAN_W-1:0] mant,
   output logic [LZC_W-1:0] lzc
);

   // Scan upward so the highest set bit is the last one to write the count.
   always_comb begin
      lzc = LZC_W'(MAN_W);
      for (int i = 0; i < MAN_W; i++) begin
         if (mant[i]) lzc = LZC_W'(MAN_W - 1 - i);
      end
   end

endmodule

// File: rtl/norm_sequencer.sv
// Post-add normalization sequencer driving an external exponent adjuster.
// Optional build macro NORM_STICKY_EN adds the out_sticky output.
//
// state   | meaning
// IDLE    | ready for a new raw sum
// ANALYZE | classify the captured sum, pick shift direction / amount
// ISSUE   | pulse adj_en to the exponent adjuster
// CAPTURE | register the adjuster result as the output exponent
// DONE    | hold the normalized result until downstream accepts
module norm_sequencer
   import fp_add_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF,
   parameter int LZC_W = LZC_W_DEF
) (
   input  logic             clk,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic             in_carry,
   input  logic [MAN_W-1:0] in_mant,
   input  logic [EXP_W-1:0] in_exp,
   output logic             adj_en,
   output logic             adj_mode,
   output logic [LZC_W-1:0] adj_value,
   output logic [EXP_W-1:0] adj_in,
   input  logic [EXP_W-1:0] adj_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_sign,
   output logic [MAN_W-1:0] out_mant,
   output logic [EXP_W-1:0] out_exp,
   output logic             out_zero,
   output logic             out_ovf
`ifdef NORM_STICKY_EN
   ,
   output logic             out_sticky
`endif
);

   localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
   localparam logic [EXP_W-1:0] EXP_NEAR = EXP_ALL1 - EXP_W'(1);

   norm_state_t state_q, state_d;

   logic             sign_q, carry_q;
   logic [MAN_W-1:0] mant_q;
   logic [EXP_W-1:0] exp_q;
   logic [LZC_W-1:0] lzc;

   logic             bypass_d, en_d, mode_d, zero_d, ovf_d;
   logic [LZC_W-1:0] value_d;
   logic [MAN_W-1:0] mant_n_d;
   logic [EXP_W-1:0] exp_n_d;

   logic             en_q, mode_q;
   logic [LZC_W-1:0] value_q;
   logic             out_sign_q, out_zero_q, out_ovf_q;
   logic [MAN_W-1:0] out_mant_q;
   logic [EXP_W-1:0] out_exp_q;

   lzc_counter #(
      .MAN_W (MAN_W),
      .LZC_W (LZC_W)
   ) u_lzc (
      .mant (mant_q),
      .lzc  (lzc)
   );

   always_ff @(posedge clk) begin
      if (flush) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = ANALYZE;
         ANALYZE: state_d = bypass_d ? DONE : ISSUE;
         ISSUE:   state_d = CAPTURE;
         CAPTURE: state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      adj_en    = 1'b0;
      adj_mode  = ADJ_INC;
      adj_value = '0;
      out_valid = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         ANALYZE: begin
            adj_mode  = mode_d;
            adj_value = value_d;
         end
         ISSUE: begin
            adj_en    = en_q;
            adj_mode  = mode_q;
            adj_value = value_q;
         end
         CAPTURE: begin
            adj_mode  = mode_q;
            adj_value = value_q;
         end
         DONE: begin
            adj_mode  = mode_q;
            adj_value = value_q;
            out_valid = 1'b1;
         end
         default: ;
      endcase
   end

   // Classification, in priority order: inf/NaN, carry, zero, underflow, left shift.
   always_comb begin
      bypass_d = 1'b0;
      en_d     = 1'b0;
      mode_d   = ADJ_INC;
      value_d  = '0;
      mant_n_d = mant_q;
      exp_n_d  = exp_q;
      zero_d   = 1'b0;
      ovf_d    = 1'b0;
      if (exp_q == EXP_ALL1) begin
         bypass_d = 1'b1;
      end else if (carry_q) begin
         en_d     = 1'b1;
         mant_n_d = {1'b1, mant_q[MAN_W-1:1]};
         if (exp_q == EXP_NEAR) begin
            bypass_d = 1'b1;
            en_d     = 1'b0;
            ovf_d    = 1'b1;
            exp_n_d  = EXP_ALL1;
            mant_n_d = '0;
         end
      end else if (mant_q == '0) begin
         bypass_d = 1'b1;
         zero_d   = 1'b1;
         exp_n_d  = '0;
         mant_n_d = '0;
      end else if (32'(lzc) >= 32'(exp_q)) begin
         bypass_d = 1'b1;
         zero_d   = 1'b1;
         exp_n_d  = '0;
         mant_n_d = '0;
      end else if (lzc != '0) begin
         en_d     = 1'b1;
         mode_d   = ADJ_DEC;
         value_d  = lzc;
         mant_n_d = mant_q << lzc;
      end
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         sign_q     <= 1'b0;
         carry_q    <= 1'b0;
         mant_q     <= '0;
         exp_q      <= '0;
         en_q       <= 1'b0;
         mode_q     <= ADJ_INC;
         value_q    <= '0;
         out_sign_q <= 1'b0;
         out_mant_q <= '0;
         out_exp_q  <= '0;
         out_zero_q <= 1'b0;
         out_ovf_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  sign_q  <= in_sign;
                  carry_q <= in_carry;
                  mant_q  <= in_mant;
                  exp_q   <= in_exp;
               end
            end
            ANALYZE: begin
               en_q       <= en_d;
               mode_q     <= mode_d;
               value_q    <= value_d;
               out_sign_q <= sign_q;
               out_mant_q <= mant_n_d;
               out_exp_q  <= exp_n_d;
               out_zero_q <= zero_d;
               out_ovf_q  <= ovf_d;
            end
            CAPTURE: out_exp_q <= adj_out;
            default: ;
         endcase
      end
   end

`ifdef NORM_STICKY_EN
   logic sticky_q;

   always_ff @(posedge clk) begin
      if (flush) begin
         sticky_q <= 1'b0;
      end else if (state_q == ANALYZE) begin
         sticky_q <= (exp_q != EXP_ALL1) && carry_q && mant_q[0];
      end
   end

   assign out_sticky = sticky_q;
`endif

   assign adj_in   = exp_q;
   assign out_sign = out_sign_q;
   assign out_mant = out_mant_q;
   assign out_exp  = out_exp_q;
   assign out_zero = out_zero_q;
   assign out_ovf  = out_ovf_q;

endmodule
